// File: rtl/controller_core.sv
// Microcoded control unit for the CDECv 8-bit CPU: steps fetch, operand and
// execute states and drives the Xbus selects, ALU op and write strobes.
module controller_core (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] I,
  input  logic [2:0] SZCy,
  output logic [2:0] xsrc,
  output logic [2:0] xdst,
  output logic [3:0] aluop,
  output logic       Rwe,
  output logic       FLGwe,
  output logic       mem_we,
  output logic       halted,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    F0 = 4'd0, F1 = 4'd1, F2 = 4'd2, F3 = 4'd3,
    M0 = 4'd4, M1 = 4'd5, M2 = 4'd6, M3 = 4'd7, M4 = 4'd8, M5 = 4'd9,
    E0 = 4'd10, E1 = 4'd11, E2 = 4'd12, HALT = 4'd13
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_HALT = 4'h1, OP_MOV = 4'h2,
                         OP_LD = 4'h3, OP_ST = 4'h4, OP_JCC = 4'hC;

  localparam logic [2:0] S_PC = 3'd0, S_A = 3'd1, S_R = 3'd4, S_RD = 3'd5, S_FF = 3'd7;
  localparam logic [2:0] D_PC = 3'd0, D_A = 3'd1, D_MAR = 3'd4, D_WDR = 3'd5,
                         D_T = 3'd6, D_I = 3'd7;

  state_t     state, state_n;
  logic [3:0] opc;
  logic [1:0] rd, rs;

  assign opc = I[7:4];
  assign rd  = I[3:2];
  assign rs  = I[1:0];

  function automatic logic is_alu(input logic [3:0] o);
    return (o >= 4'h5) && (o <= 4'hA);
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] o);
    case (o)
      4'h5:    return 4'b0010;
      4'h6:    return 4'b0100;
      4'h7:    return 4'b0110;
      4'h8:    return 4'b0111;
      4'h9:    return 4'b1000;
      4'hA:    return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic cond_met(input logic [1:0] cc, input logic [2:0] f);
    case (cc)
      2'b00:   return 1'b1;
      2'b01:   return f[1];
      2'b10:   return f[0];
      default: return f[2];
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) state <= F0;
    else        state <= state_n;
  end

  always_comb begin
    state_n = F0;
    case (state)
      F0: state_n = run ? F1 : F0;
      F1: state_n = F2;
      F2: state_n = F3;
      // Decode: rd of 00 collapses MOV/ALU/LD into a no-op instruction
      F3: begin
        if (opc == OP_HALT)                    state_n = HALT;
        else if (opc == OP_MOV && rd != 2'b00) state_n = (rs != 2'b00) ? E2 : M0;
        else if (opc == OP_LD && rd != 2'b00)  state_n = M0;
        else if (opc == OP_ST || opc == OP_JCC) state_n = M0;
        else if (is_alu(opc) && rd != 2'b00)   state_n = (rs != 2'b00) ? E0 : M0;
        else                                   state_n = F0;
      end
      M0: state_n = M1;
      M1: state_n = M2;
      M2: state_n = M3;
      M3: begin
        if (opc == OP_LD || opc == OP_ST) state_n = M4;
        else if (is_alu(opc))             state_n = E1;
        else                              state_n = F0;
      end
      M4: state_n = M5;
      M5: state_n = F0;
      E0: state_n = E1;
      E1: state_n = E2;
      E2: state_n = F0;
      HALT: state_n = HALT;
      default: state_n = F0;
    endcase
  end

  // Register codes 01/10/11 coincide with the A/B/C select encodings
  always_comb begin
    xsrc   = S_A;
    xdst   = D_A;
    aluop  = 4'b0000;
    FLGwe  = 1'b0;
    mem_we = 1'b0;
    case (state)
      F0: if (run) begin xsrc = S_PC; xdst = D_MAR; end
      F1: begin xsrc = S_PC; xdst = D_T; aluop = 4'b0001; end
      F2: begin xsrc = S_RD; xdst = D_I; end
      F3: begin xsrc = S_R; xdst = D_PC; end
      M0: begin xsrc = S_PC; xdst = D_MAR; end
      M1: begin xsrc = S_PC; xdst = D_T; aluop = 4'b0001; end
      M2: begin xsrc = S_R; xdst = D_PC; end
      M3: begin
        if (opc == OP_MOV) begin xsrc = S_RD; xdst = {1'b0, rd}; end
        else if (opc == OP_LD || opc == OP_ST) begin xsrc = S_RD; xdst = D_MAR; end
        else if (is_alu(opc)) begin xsrc = S_RD; xdst = D_T; end
        else if (opc == OP_JCC && cond_met(rs, SZCy)) begin xsrc = S_RD; xdst = D_PC; end
      end
      M4: if (opc == OP_ST) begin
        xsrc = (rs == 2'b00) ? S_FF : {1'b0, rs};
        xdst = D_WDR;
      end
      M5: begin
        if (opc == OP_LD) begin xsrc = S_RD; xdst = {1'b0, rd}; end
        else if (opc == OP_ST) mem_we = 1'b1;
      end
      E0: begin xsrc = {1'b0, rs}; xdst = D_T; end
      E1: begin xsrc = {1'b0, rd}; xdst = D_T; aluop = alu_code(opc); FLGwe = 1'b1; end
      E2: begin
        xsrc = (opc == OP_MOV) ? {1'b0, rs} : S_R;
        xdst = {1'b0, rd};
      end
      default: ;
    endcase
  end

  assign Rwe       = (xdst == D_T);
  assign halted    = (state == HALT);
  assign dbg_state = state;

endmodule

// File: tb/tb_controller_core.sv
// Bench for controller_core: per-cycle vector table with a scoreboard queue,
// plus hand-written sequences for run gating, strobes, HALT and reset.
module tb_controller_core;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [7:0] I = 8'h00;
  logic [2:0] SZCy = 3'b000;
  logic [2:0] xsrc, xdst;
  logic [3:0] aluop;
  logic       Rwe, FLGwe, mem_we, halted;
  logic [3:0] dbg_state;

  int checks = 0;
  int errors = 0;

  controller_core dut (
    .clock(clock), .reset(reset), .run(run), .I(I), .SZCy(SZCy),
    .xsrc(xsrc), .xdst(xdst), .aluop(aluop), .Rwe(Rwe), .FLGwe(FLGwe),
    .mem_we(mem_we), .halted(halted), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rn;
    logic       rr;
    logic [7:0] i;
    logic [2:0] f;
    logic [3:0] st;
    logic [2:0] xs;
    logic [2:0] xd;
    logic [3:0] op;
    logic       fl;
    logic       we;
    logic       hl;
  } vec_t;

  vec_t        tbl[$];
  logic [17:0] sb[$];

  task automatic add(input logic rn, input logic rr, input logic [7:0] i, input logic [2:0] f,
                     input logic [3:0] st, input logic [2:0] xs, input logic [2:0] xd,
                     input logic [3:0] op, input logic fl, input logic we, input logic hl);
    vec_t v;
    v.rn = rn; v.rr = rr; v.i = i; v.f = f; v.st = st; v.xs = xs; v.xd = xd;
    v.op = op; v.fl = fl; v.we = we; v.hl = hl;
    tbl.push_back(v);
  endtask

  task automatic fetch(input logic [7:0] i, input logic [2:0] f);
    add(1, 1, i, f, 4'd0, 3'd0, 3'd4, 4'b0000, 0, 0, 0);
    add(1, 1, i, f, 4'd1, 3'd0, 3'd6, 4'b0001, 0, 0, 0);
    add(1, 1, i, f, 4'd2, 3'd5, 3'd7, 4'b0000, 0, 0, 0);
    add(1, 1, i, f, 4'd3, 3'd4, 3'd0, 4'b0000, 0, 0, 0);
  endtask

  task automatic opnd(input logic [7:0] i, input logic [2:0] f);
    add(1, 1, i, f, 4'd4, 3'd0, 3'd4, 4'b0000, 0, 0, 0);
    add(1, 1, i, f, 4'd5, 3'd0, 3'd6, 4'b0001, 0, 0, 0);
    add(1, 1, i, f, 4'd6, 3'd4, 3'd0, 4'b0000, 0, 0, 0);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rn, input logic rr, input logic [7:0] i, input logic [2:0] f);
    @(negedge clock);
    reset = rn; run = rr; I = i; SZCy = f;
    #2;
  endtask

  function automatic logic [17:0] pack_exp(input vec_t v);
    return {v.st, v.xs, v.xd, v.op, v.fl, v.we, v.hl, (v.xd == 3'd6)};
  endfunction

  initial begin
    int n, cnt, cnt2;
    logic [2:0] m4_src;
    logic [17:0] e, a;

    // Idle after reset: F0 issues NOP while run is low
    for (int k = 0; k < 5; k++) add(1, 0, 8'h00, 3'b000, 4'd0, 3'd1, 3'd1, 4'b0000, 0, 0, 0);
    // MOV B,A (register form)
    fetch(8'h29, 3'b000);
    add(1, 1, 8'h29, 3'b000, 4'd12, 3'd1, 3'd2, 4'b0000, 0, 0, 0);
    // ADD B,C (register form)
    fetch(8'h5B, 3'b000);
    add(1, 1, 8'h5B, 3'b000, 4'd10, 3'd3, 3'd6, 4'b0000, 0, 0, 0);
    add(1, 1, 8'h5B, 3'b000, 4'd11, 3'd2, 3'd6, 4'b0010, 1, 0, 0);
    add(1, 1, 8'h5B, 3'b000, 4'd12, 3'd4, 3'd2, 4'b0000, 0, 0, 0);
    // ST C,[imm]
    fetch(8'h43, 3'b000); opnd(8'h43, 3'b000);
    add(1, 1, 8'h43, 3'b000, 4'd7, 3'd5, 3'd4, 4'b0000, 0, 0, 0);
    add(1, 1, 8'h43, 3'b000, 4'd8, 3'd3, 3'd5, 4'b0000, 0, 0, 0);
    add(1, 1, 8'h43, 3'b000, 4'd9, 3'd1, 3'd1, 4'b0000, 0, 1, 0);
    // JZ taken, then not taken
    fetch(8'hC1, 3'b010); opnd(8'hC1, 3'b010);
    add(1, 1, 8'hC1, 3'b010, 4'd7, 3'd5, 3'd0, 4'b0000, 0, 0, 0);
    fetch(8'hC1, 3'b000); opnd(8'hC1, 3'b000);
    add(1, 1, 8'hC1, 3'b000, 4'd7, 3'd1, 3'd1, 4'b0000, 0, 0, 0);
    // LD A,[imm]
    fetch(8'h34, 3'b000); opnd(8'h34, 3'b000);
    add(1, 1, 8'h34, 3'b000, 4'd7, 3'd5, 3'd4, 4'b0000, 0, 0, 0);
    add(1, 1, 8'h34, 3'b000, 4'd8, 3'd1, 3'd1, 4'b0000, 0, 0, 0);
    add(1, 1, 8'h34, 3'b000, 4'd9, 3'd5, 3'd1, 4'b0000, 0, 0, 0);
    // SUB C,#imm
    fetch(8'h6C, 3'b000); opnd(8'h6C, 3'b000);
    add(1, 1, 8'h6C, 3'b000, 4'd7, 3'd5, 3'd6, 4'b0000, 0, 0, 0);
    add(1, 1, 8'h6C, 3'b000, 4'd11, 3'd3, 3'd6, 4'b0100, 1, 0, 0);
    add(1, 1, 8'h6C, 3'b000, 4'd12, 3'd4, 3'd3, 4'b0000, 0, 0, 0);
    // Reset in M4 of a store: back to F0, no write strobe
    fetch(8'h43, 3'b000); opnd(8'h43, 3'b000);
    add(1, 1, 8'h43, 3'b000, 4'd7, 3'd5, 3'd4, 4'b0000, 0, 0, 0);
    add(0, 1, 8'h43, 3'b000, 4'd8, 3'd3, 3'd5, 4'b0000, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 8'h43, 3'b000, 4'd0, 3'd1, 3'd1, 4'b0000, 0, 0, 0);

    step(0, 0, 8'h00, 3'b000);
    step(0, 0, 8'h00, 3'b000);

    foreach (tbl[k]) begin
      @(negedge clock);
      reset = tbl[k].rn; run = tbl[k].rr; I = tbl[k].i; SZCy = tbl[k].f;
      sb.push_back(pack_exp(tbl[k]));
      #2;
      e = sb.pop_front();
      a = {dbg_state, xsrc, xdst, aluop, FLGwe, mem_we, halted, Rwe};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL vec[%0d]: got %05h expected %05h", k, a, e);
      end
    end

    // ADC A,B with run dropped after F0: instruction still completes, one FLGwe
    step(1, 1, 8'hA6, 3'b000);
    n = 1; cnt = FLGwe;
    do begin
      step(1, 0, 8'hA6, 3'b000);
      n++; cnt += FLGwe;
    end while (dbg_state != 4'd0 && n < 20);
    check("adc_cycles", n - 1, 7);
    check("adc_flgwe_count", cnt, 1);
    check("adc_aluop_idle", aluop, 4'b0000);

    // ST with rs=00 stores FFh, single mem_we
    step(1, 1, 8'h40, 3'b000);
    n = 1; cnt = mem_we; m4_src = 3'd0;
    do begin
      step(1, 0, 8'h40, 3'b000);
      n++; cnt += mem_we;
      if (dbg_state == 4'd8) m4_src = xsrc;
    end while (dbg_state != 4'd0 && n < 20);
    check("st_ff_cycles", n - 1, 10);
    check("st_ff_memwe_count", cnt, 1);
    check("st_ff_src", m4_src, 3'd7);

    // HALT holds for 20 cycles, then reset releases it
    for (int k = 0; k < 4; k++) step(1, 1, 8'h10, 3'b000);
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 8'h10, 3'b000);
      if (halted === 1'b1) cnt++;
      if (dbg_state == 4'd13 && xsrc == 3'd1 && xdst == 3'd1 && mem_we == 1'b0) cnt2++;
    end
    check("halt_cycles", cnt, 20);
    check("halt_nop_cycles", cnt2, 20);
    step(0, 1, 8'h10, 3'b000);
    step(1, 0, 8'h10, 3'b000);
    check("halt_reset_state", dbg_state, 4'd0);
    check("halt_reset_halted", halted, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
